// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: FSM state encoding
// and default geometry.
package rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t CLEAR = 1'b1;

endpackage

// File: rtl/rf_rd_port.sv
// One asynchronous read port: same-cycle write forwarding (port 1 wins),
// zero-register masking and forced-zero while the array is being cleared.
module rf_rd_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              busy_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = stored_i;
        if (BYPASS != 0) begin
            if (we0_i && (wa0_i == addr_i)) data_o = wd0_i;
            // Checked last so that port 1 overrides port 0 on a shared address.
            if (we1_i && (wa1_i == addr_i)) data_o = wd1_i;
        end
        if (busy_i || ((ZERO_REG != 0) && (addr_i == '0))) data_o = '0;
    end

endmodule

// File: rtl/rf_multiport.sv
// Dual-write, NRD-read register file with a sequential clear sweep that is
// started by reset or by a clear request while idle.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  clr_busy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic                  wr_conflict
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              conf_q, conf_d;
    logic [DATA_W-1:0] mem_q [NREG];

    logic busy;
    logic wen0, wen1;

    // rst is folded in so the array reads as busy even on the first reset cycle.
    assign busy     = rst || (state_q == CLEAR);
    assign clr_busy = busy;

    assign wen0 = we0 && !busy && !((ZERO_REG != 0) && (wa0 == '0));
    assign wen1 = we1 && !busy && !((ZERO_REG != 0) && (wa1 == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        conf_d  = 1'b0;
        if (rst) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            conf_d = wen0 && wen1 && (wa0 == wa1);
            if (clr_req) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_IDX) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        conf_q  <= conf_d;
    end

    assign wr_conflict = conf_q;

    // Port 1 is assigned second so it wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wen0) mem_q[wa0] <= wd0;
            if (wen1) mem_q[wa1] <= wd1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = ra[k*ADDR_W +: ADDR_W];

        rf_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .addr_i  (addr),
            .stored_i(mem_q[addr]),
            .busy_i  (busy),
            .we0_i   (wen0),
            .wa0_i   (wa0),
            .wd0_i   (wd0),
            .we1_i   (wen1),
            .wa1_i   (wa1),
            .wd1_i   (wd1),
            .data_o  (rd[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport (default parameters): vector table, directed clear and
// reset sequences, then randomized traffic against an array-level model.
module tb_rf_multiport;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        rst, clr_req, clr_busy, wr_conflict;
    logic        we0, we1;
    logic [4:0]  wa0, wa1, ra0, ra1;
    logic [31:0] wd0, wd1;
    logic [9:0]  ra;
    logic [63:0] rd;

    assign ra = {ra1, ra0};

    always #5 clk = ~clk;

    rf_multiport dut (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .we0        (we0),
        .wa0        (wa0),
        .wd0        (wd0),
        .we1        (we1),
        .wa1        (wa1),
        .wd1        (wd1),
        .ra         (ra),
        .rd         (rd),
        .wr_conflict(wr_conflict)
    );

    int checks = 0;
    int failures = 0;

    // Model: contents as seen once any clear has completed, plus clear cycles left.
    logic [31:0] m_mem [NREG];
    int          m_clear_left = NREG;
    logic        m_conf = 1'b0;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_conf;
    } vec_t;

    vec_t vec [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (rst || (m_clear_left > 0)) return '0;
        if (a == 5'd0) return '0;
        if (we1 && (wa1 == a)) return wd1;
        if (we0 && (wa0 == a)) return wd0;
        return m_mem[a];
    endfunction

    task automatic m_zero();
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            m_clear_left = NREG;
            m_conf = 1'b0;
            m_zero();
        end else if (m_clear_left > 0) begin
            m_clear_left--;
            m_conf = 1'b0;
        end else begin
            m_conf = we0 && we1 && (wa0 == wa1) && (wa0 != 5'd0);
            if (we0 && (wa0 != 5'd0)) m_mem[wa0] = wd0;
            if (we1 && (wa1 != 5'd0)) m_mem[wa1] = wd1;
            if (clr_req) begin
                m_clear_left = NREG;
                m_zero();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; clr_req = 1'b0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
    endtask

    task automatic check_model(input string tag);
        #3;
        chk({tag, "_rd0"}, rd[31:0], m_read(ra0));
        chk({tag, "_rd1"}, rd[63:32], m_read(ra1));
        chk({tag, "_busy"}, 32'(clr_busy), 32'(rst || (m_clear_left > 0)));
        chk({tag, "_conf"}, 32'(wr_conflict), 32'(m_conf));
    endtask

    // Counts busy cycles (bounded), requiring rd=0 throughout; leaves inputs idle.
    task automatic count_busy(input string tag, output int n);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            #3;
            if (!clr_busy) break;
            n++;
            chk({tag, "_rd0_zero"}, rd[31:0], 32'h0);
            chk({tag, "_rd1_zero"}, rd[63:32], 32'h0);
            @(posedge clk);
            model_edge();
            #1;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        vec[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        1'b0};
        vec[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vec[2]  = '{1'b1, 5'd7,  32'h1,        1'b1, 5'd7,  32'h2,        5'd7,  5'd5,  32'h2,        32'hDEADBEEF, 1'b0};
        vec[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h2,        32'h0,        1'b1};
        vec[4]  = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'h2,        1'b0};
        vec[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h2,        1'b0};
        vec[6]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd4,  32'hB,        5'd3,  5'd4,  32'hA,        32'hB,        1'b0};
        vec[7]  = '{1'b1, 5'd3,  32'hC,        1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'hC,        32'hB,        1'b0};
        vec[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'hC,        32'hB,        1'b0};
        vec[9]  = '{1'b1, 5'd31, 32'h66,       1'b1, 5'd31, 32'h77,       5'd31, 5'd3,  32'h77,       32'hC,        1'b0};
        vec[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h77,       32'h77,       1'b1};

        idle_inputs();
        ra0 = '0; ra1 = '0;
        m_zero();

        // One-cycle reset pulse, then the sweep must last exactly NREG cycles.
        rst = 1'b1;
        #3;
        chk("rst_busy_high", 32'(clr_busy), 32'h1);
        chk("rst_rd0_zero", rd[31:0], 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_conf_zero", 32'(wr_conflict), 32'h0);
        #0;
        count_busy("rst_sweep", n);
        chk("rst_busy_len", n, 32'd32);

        for (int i = 0; i < NREG; i++) begin
            ra0 = 5'(i);
            ra1 = 5'(NREG - 1 - i);
            #3;
            chk($sformatf("post_rst_rd0_a%0d", i), rd[31:0], 32'h0);
            chk($sformatf("post_rst_rd1_a%0d", NREG - 1 - i), rd[63:32], 32'h0);
            tick();
        end

        for (int i = 0; i < 11; i++) begin
            we0 = vec[i].we0; wa0 = vec[i].wa0; wd0 = vec[i].wd0;
            we1 = vec[i].we1; wa1 = vec[i].wa1; wd1 = vec[i].wd1;
            ra0 = vec[i].ra0; ra1 = vec[i].ra1;
            #3;
            chk($sformatf("vec%0d_rd0", i), rd[31:0], vec[i].e_rd0);
            chk($sformatf("vec%0d_rd1", i), rd[63:32], vec[i].e_rd1);
            chk($sformatf("vec%0d_busy", i), 32'(clr_busy), 32'h0);
            chk($sformatf("vec%0d_conf", i), 32'(wr_conflict), 32'(vec[i].e_conf));
            tick();
        end
        idle_inputs();

        // Clear requested alongside a write; writes during the sweep are dropped.
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55; ra0 = 5'd9; ra1 = 5'd10;
        check_model("ct_w9");
        tick();
        clr_req = 1'b1; we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h66; ra0 = 5'd10; ra1 = 5'd9;
        #3;
        chk("ct_req_rd0_fwd", rd[31:0], 32'h66);
        chk("ct_req_rd1_old", rd[63:32], 32'h55);
        chk("ct_req_busy", 32'(clr_busy), 32'h0);
        tick();
        clr_req = 1'b1;
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hBAD0;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'hBAD1;
        ra0 = 5'd9; ra1 = 5'd10;
        count_busy("ct_sweep", n);
        chk("ct_busy_len", n, 32'd32);
        ra0 = 5'd9; ra1 = 5'd10;
        #3;
        chk("ct_after_a9", rd[31:0], 32'h0);
        chk("ct_after_a10", rd[63:32], 32'h0);
        tick();
        ra0 = 5'd1; ra1 = 5'd2;
        #3;
        chk("ct_after_a1", rd[31:0], 32'h0);
        chk("ct_after_a2", rd[63:32], 32'h0);
        tick();

        // Reset on sweep cycle 20 restarts the full sweep.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #3;
            chk($sformatf("ms_busy_c%0d", k), 32'(clr_busy), 32'h1);
            tick();
        end
        rst = 1'b1;
        #3;
        chk("ms_rst_busy", 32'(clr_busy), 32'h1);
        chk("ms_rst_rd0", rd[31:0], 32'h0);
        tick();
        rst = 1'b0;
        count_busy("ms_sweep", n);
        chk("ms_busy_len", n, 32'd32);

        for (int c = 0; c < 800; c++) begin
            rst     = ($urandom_range(0, 149) == 0);
            clr_req = ($urandom_range(0, 59) == 0);
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            wa0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wa1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ra0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wd0 = $urandom;
            wd1 = $urandom;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 Parameter DATA_W, default 32: width of each register in bits.
REQ-002 Parameter ADDR_W, default 5: address width; NREG = 2**ADDR_W entries.
REQ-003 Parameter NRD, default 2: number of asynchronous read ports.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = no forwarding.
REQ-005 Parameter ZERO_REG, default 1: 1 = entry 0 is hardwired to zero.
REQ-006 clk  in  1  clock; all state updates occur on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 clr_req  in  1  request a full-array clear while the block is idle.
REQ-009 clr_busy  out  1  high while the clear sweep is in progress.
REQ-010 we0 / wa0 / wd0  in  1 / ADDR_W / DATA_W  write port 0: enable, address, data.
REQ-011 we1 / wa1 / wd1  in  1 / ADDR_W / DATA_W  write port 1: enable, address, data.
REQ-012 ra  in  NRD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-013 rd  out  NRD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-014 wr_conflict  out  1  registered flag: same-address dual write occurred in the previous cycle.

Function
REQ-015 The FSM SHALL have two states: IDLE and CLEAR.
REQ-016 In CLEAR, one entry per cycle SHALL be written with zero, using a sweep counter that runs 0 .. NREG-1.
REQ-017 CLEAR SHALL last exactly NREG cycles and then return to IDLE; clr_busy SHALL equal (state == CLEAR).
REQ-018 In IDLE, clr_req=1 SHALL enter CLEAR on the next edge; writes presented in that same cycle SHALL still be committed.
REQ-019 In CLEAR, clr_req, we0 and we1 SHALL be ignored.
REQ-020 In CLEAR, every rd port SHALL return 0.
REQ-021 Writes SHALL commit on the edge in which we is sampled high; write latency is one cycle.
REQ-022 Reads SHALL be combinational from ra with zero latency.
REQ-023 When we0 and we1 target the same address, port 1 SHALL win.
REQ-024 In that same-address case, wr_conflict SHALL be 1 on the following cycle; otherwise it SHALL be 0.
REQ-025 BYPASS=1: a read whose address matches an enabled write in the same cycle SHALL return that write's data, with port 1 taking priority.
REQ-026 BYPASS=0: such a read SHALL return the stored (old) value.
REQ-027 ZERO_REG=1: writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and address 0 SHALL never be forwarded or flagged as a conflict.
REQ-028 Addresses SHALL be used modulo NREG; no out-of-range case exists.

Reset
REQ-029 rst=1 SHALL force state to CLEAR, reset the sweep counter to 0, and set wr_conflict to 0.
REQ-030 The array contents are therefore zeroed NREG cycles after rst deasserts; the array is not cleared in a single cycle.
REQ-031 rst asserted in the middle of a sweep SHALL restart the sweep from entry 0.
REQ-032 While rst is high, clr_busy SHALL be 1 and rd SHALL be 0.
REQ-033 There SHALL be no initial blocks; all state SHALL be defined by rst.

Structure
REQ-034 A shared package rf_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the default DATA_W and ADDR_W constants.
REQ-035 The write-priority and bypass mux for one read port SHALL be a sub-module rf_rd_port, instantiated NRD times in a generate loop.
REQ-036 Storage SHALL be a single 2-D register array updated in one clocked process.

Verification
REQ-037 Reset test: pulse rst for 1 cycle -> clr_busy high for exactly 32 cycles; afterwards, reading all 32 addresses returns 0.
REQ-038 Basic write/read: we0=1, wa0=5, wd0=32'hDEADBEEF -> ra port 0 = 5 returns DEADBEEF from the next cycle on; with BYPASS=1 it also returns DEADBEEF in the same cycle.
REQ-039 Dual-write conflict: we0 wa0=7 wd0=1 and we1 wa1=7 wd1=2 in the same cycle -> entry 7 = 2, and wr_conflict=1 for one cycle.
REQ-040 Zero register: we1=1, wa1=0, wd1=32'hFFFFFFFF -> rd returns 0 for address 0, and wr_conflict stays 0.
REQ-041 Clear during traffic: write 9=32'h55, then clr_req plus a write 10=32'h66 in the same cycle -> 10 is written, then the sweep runs 32 cycles with rd=0 and writes ignored; afterwards entries 9 and 10 read 0.
REQ-042 Mid-sweep reset: assert rst on sweep cycle 20 -> clr_busy stays high for a further 32 cycles after rst deasserts.
